// File: rtl/lf_pulse_sequencer_pkg.sv
// Shared definitions for the LF reader pulse sequencer: default widths and
// the sequencer state encoding.
package lf_pulse_sequencer_pkg;

  localparam int LEN_W_DEF = 8;
  localparam int DIV_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_GAP = 3'd1,
    ST_BIT_GAP   = 3'd2,
    ST_BIT_ON    = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_t;

endpackage

// File: rtl/lf_pulse_sequencer_prescaler.sv
// Tick prescaler: counts 0..divisor while enabled and flags the wrap cycle as
// a tick; a synchronous clear restarts the count phase.
module lf_tick_prescaler
  import lf_pulse_sequencer_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             pck0,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = enable && (count == divisor);

  // Phase counter; idles at zero outside a frame.
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/lf_pulse_sequencer.sv
// LF reader pulse sequencer: turns a stream of command bits into field-off
// gaps and field-on intervals whose length encodes each bit value.
module lf_pulse_sequencer
  import lf_pulse_sequencer_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             pck0,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic [LEN_W-1:0] start_gap,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [LEN_W-1:0] zero_len,
  input  logic [LEN_W-1:0] one_len,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bit,
  input  logic             cmd_last,
  input  logic             abort,
  output logic             field_on,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  seq_state_t       state, state_nxt;
  logic             cur_bit, cur_bit_nxt, cur_last, cur_last_nxt;
  logic             nbuf_full, nbuf_full_nxt, nbuf_bit, nbuf_bit_nxt, nbuf_last, nbuf_last_nxt;
  logic             stalled, stalled_nxt, underrun_nxt, ready_nxt;
  logic [LEN_W-1:0] ivl_cnt, ivl_cnt_nxt, ivl_len;
  logic [LEN_W-1:0] cfg_start_gap, cfg_gap_len, cfg_zero_len, cfg_one_len;
  logic [DIV_W-1:0] cfg_divisor;
  logic             tick, ivl_end, xfer, active, presc_clear, load_cfg;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len == '0) begin
      eff_len = LEN_ONE;
    end else begin
      eff_len = len;
    end
  endfunction

  lf_tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .pck0    (pck0),
    .rst     (rst),
    .clear   (presc_clear),
    .enable  (state != ST_IDLE),
    .divisor (cfg_divisor),
    .tick    (tick)
  );

  assign xfer    = cmd_valid && cmd_ready;
  assign active  = (state == ST_START_GAP) || (state == ST_BIT_GAP) || (state == ST_BIT_ON);
  assign ivl_end = tick && (ivl_cnt == ivl_len - LEN_ONE);

  // Length of the interval the current state is timing.
  always_comb begin
    ivl_len = eff_len(cfg_zero_len);
    case (state)
      ST_START_GAP: ivl_len = eff_len(cfg_start_gap);
      ST_BIT_GAP:   ivl_len = eff_len(cfg_gap_len);
      ST_BIT_ON:    ivl_len = cur_bit ? eff_len(cfg_one_len) : eff_len(cfg_zero_len);
      default:      ivl_len = eff_len(cfg_zero_len);
    endcase
  end

  // Next-state, bit buffering and interval bookkeeping.
  always_comb begin
    state_nxt     = state;
    cur_bit_nxt   = cur_bit;
    cur_last_nxt  = cur_last;
    nbuf_full_nxt = nbuf_full;
    nbuf_bit_nxt  = nbuf_bit;
    nbuf_last_nxt = nbuf_last;
    ivl_cnt_nxt   = ivl_cnt;
    stalled_nxt   = stalled;
    underrun_nxt  = underrun;
    presc_clear   = 1'b0;
    load_cfg      = 1'b0;
    if (abort && active) begin
      state_nxt     = ST_DONE;
      nbuf_full_nxt = 1'b0;
      stalled_nxt   = 1'b0;
      ivl_cnt_nxt   = '0;
    end else begin
      if (xfer && active) begin
        nbuf_full_nxt = 1'b1;
        nbuf_bit_nxt  = cmd_bit;
        nbuf_last_nxt = cmd_last;
      end else begin
        nbuf_full_nxt = nbuf_full;
      end
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            cur_bit_nxt   = cmd_bit;
            cur_last_nxt  = cmd_last;
            nbuf_full_nxt = 1'b0;
            load_cfg      = 1'b1;
            presc_clear   = 1'b1;
            underrun_nxt  = 1'b0;
            stalled_nxt   = 1'b0;
            ivl_cnt_nxt   = '0;
            state_nxt     = ST_START_GAP;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_START_GAP, ST_BIT_GAP: begin
          if (ivl_end) begin
            ivl_cnt_nxt = '0;
            state_nxt   = ST_BIT_ON;
          end else if (tick) begin
            ivl_cnt_nxt = ivl_cnt + LEN_ONE;
          end else begin
            ivl_cnt_nxt = ivl_cnt;
          end
        end
        ST_BIT_ON: begin
          if (stalled) begin
            // Field stays on until a late bit lands; its gap starts on a fresh tick phase.
            if (nbuf_full) begin
              cur_bit_nxt   = nbuf_bit;
              cur_last_nxt  = nbuf_last;
              nbuf_full_nxt = 1'b0;
              stalled_nxt   = 1'b0;
              presc_clear   = 1'b1;
              ivl_cnt_nxt   = '0;
              state_nxt     = ST_BIT_GAP;
            end else begin
              stalled_nxt = 1'b1;
            end
          end else if (ivl_end) begin
            ivl_cnt_nxt = '0;
            if (cur_last) begin
              state_nxt = ST_DONE;
            end else if (nbuf_full) begin
              cur_bit_nxt   = nbuf_bit;
              cur_last_nxt  = nbuf_last;
              nbuf_full_nxt = 1'b0;
              state_nxt     = ST_BIT_GAP;
            end else begin
              stalled_nxt  = 1'b1;
              underrun_nxt = 1'b1;
            end
          end else if (tick) begin
            ivl_cnt_nxt = ivl_cnt + LEN_ONE;
          end else begin
            ivl_cnt_nxt = ivl_cnt;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Ready as seen from the state being entered.
  always_comb begin
    ready_nxt = 1'b0;
    case (state_nxt)
      ST_IDLE: ready_nxt = 1'b1;
      ST_DONE: ready_nxt = 1'b0;
      default: ready_nxt = !nbuf_full_nxt && !cur_last_nxt;
    endcase
  end

  // State, buffers and registered outputs; reset forces the field back on.
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_bit   <= 1'b0;
      cur_last  <= 1'b0;
      nbuf_full <= 1'b0;
      nbuf_bit  <= 1'b0;
      nbuf_last <= 1'b0;
      ivl_cnt   <= '0;
      stalled   <= 1'b0;
      underrun  <= 1'b0;
      field_on  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      cur_bit   <= cur_bit_nxt;
      cur_last  <= cur_last_nxt;
      nbuf_full <= nbuf_full_nxt;
      nbuf_bit  <= nbuf_bit_nxt;
      nbuf_last <= nbuf_last_nxt;
      ivl_cnt   <= ivl_cnt_nxt;
      stalled   <= stalled_nxt;
      underrun  <= underrun_nxt;
      field_on  <= !((state_nxt == ST_START_GAP) || (state_nxt == ST_BIT_GAP));
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      cmd_ready <= ready_nxt;
    end
  end

  // Frame configuration, captured only when a frame starts.
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      cfg_start_gap <= '0;
      cfg_gap_len   <= '0;
      cfg_zero_len  <= '0;
      cfg_one_len   <= '0;
      cfg_divisor   <= '0;
    end else if (load_cfg) begin
      cfg_start_gap <= start_gap;
      cfg_gap_len   <= gap_len;
      cfg_zero_len  <= zero_len;
      cfg_one_len   <= one_len;
      cfg_divisor   <= divisor;
    end else begin
      cfg_start_gap <= cfg_start_gap;
      cfg_gap_len   <= cfg_gap_len;
      cfg_zero_len  <= cfg_zero_len;
      cfg_one_len   <= cfg_one_len;
      cfg_divisor   <= cfg_divisor;
    end
  end

endmodule

// File: tb/tb_lf_pulse_sequencer.sv
// Scoreboard bench for lf_pulse_sequencer: per-cycle field/busy/done
// expectations are queued when a frame is launched and checked every cycle.
module tb_lf_pulse_sequencer;

  logic       pck0 = 1'b0;
  logic       rst;
  logic [7:0] divisor, start_gap, gap_len, zero_len, one_len;
  logic       cmd_valid, cmd_bit, cmd_last, abort;
  logic       cmd_ready, field_on, busy, done, underrun;

  typedef struct packed {
    logic field;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc, abort_at, nbits, bit_idx;
  logic bits[8];
  int   avail[8];

  always #5 pck0 = ~pck0;

  lf_pulse_sequencer dut (
    .pck0      (pck0),
    .rst       (rst),
    .divisor   (divisor),
    .start_gap (start_gap),
    .gap_len   (gap_len),
    .zero_len  (zero_len),
    .one_len   (one_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_bit   (cmd_bit),
    .cmd_last  (cmd_last),
    .abort     (abort),
    .field_on  (field_on),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  task automatic push_seg(input logic f, input logic b, input logic d, input int n);
    exp_t e;
    e.field = f;
    e.busy  = b;
    e.done  = d;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // One cycle: compare outputs on the falling edge, then drive the next inputs.
  task automatic tick_cycle();
    exp_t e;
    @(negedge pck0);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("field_on", {31'd0, field_on}, {31'd0, e.field});
      check_val("busy",     {31'd0, busy},     {31'd0, e.busy});
      check_val("done",     {31'd0, done},     {31'd0, e.done});
    end
    abort = (cyc == abort_at) || (cyc == abort_at + 3);
    if (cyc == 1) begin
      divisor   = 8'($urandom_range(0, 255));
      start_gap = 8'($urandom_range(0, 255));
      gap_len   = 8'($urandom_range(0, 255));
      zero_len  = 8'($urandom_range(0, 255));
      one_len   = 8'($urandom_range(0, 255));
    end
    if (bit_idx < nbits && cyc >= avail[bit_idx]) begin
      cmd_valid = 1'b1;
      cmd_bit   = bits[bit_idx];
      cmd_last  = (bit_idx == nbits - 1);
      if (cmd_ready) bit_idx++;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic setup(input int d, input int sg, input int g, input int z, input int o, input int ab);
    divisor   = 8'(d);
    start_gap = 8'(sg);
    gap_len   = 8'(g);
    zero_len  = 8'(z);
    one_len   = 8'(o);
    abort_at  = ab;
    bit_idx   = 0;
    cyc       = -1;
    for (int i = 0; i < 8; i++) avail[i] = 0;
    push_seg(1'b1, 1'b0, 1'b0, 1);
  endtask

  task automatic run_frame(input string name);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) tick_cycle();
    check_val({name, "_bits_taken"}, 32'(bit_idx), 32'(nbits));
    check_val({name, "_idle_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_bit = 1'b0; cmd_last = 1'b0; abort = 1'b0;
    divisor = 8'd0; start_gap = 8'd0; gap_len = 8'd0; zero_len = 8'd0; one_len = 8'd0;
    nbits = 0; bit_idx = 0; cyc = 0; abort_at = -10;
    #1;
    check_val("rst_field_on", {31'd0, field_on}, 32'd1);
    check_val("rst_busy",     {31'd0, busy},     32'd0);
    check_val("rst_done",     {31'd0, done},     32'd0);
    check_val("rst_underrun", {31'd0, underrun}, 32'd0);
    check_val("rst_ready",    {31'd0, cmd_ready}, 32'd1);
    @(negedge pck0);
    @(negedge pck0);
    rst = 1'b0;

    // Two bits, tick every cycle: 4 off, 6 on, 2 off, 3 on, done.
    nbits = 2; bits[0] = 1'b1; bits[1] = 1'b0;
    setup(0, 4, 2, 3, 6, -10);
    push_seg(1'b0, 1'b1, 1'b0, 4); push_seg(1'b1, 1'b1, 1'b0, 6);
    push_seg(1'b0, 1'b1, 1'b0, 2); push_seg(1'b1, 1'b1, 1'b0, 3);
    push_seg(1'b1, 1'b1, 1'b1, 1); push_seg(1'b1, 1'b0, 1'b0, 1);
    run_frame("basic");

    // divisor=3, unit lengths: every interval spans 4 clocks.
    nbits = 1; bits[0] = 1'b0;
    setup(3, 1, 1, 1, 1, -10);
    push_seg(1'b0, 1'b1, 1'b0, 4); push_seg(1'b1, 1'b1, 1'b0, 4);
    push_seg(1'b1, 1'b1, 1'b1, 1); push_seg(1'b1, 1'b0, 1'b0, 2);
    run_frame("div3");

    // Second bit offered late: field held on from cycle sg+1 until the
    // cycle after it is buffered (late_at+1), then gap and the bit.
    nbits = 2; bits[0] = 1'b0; bits[1] = 1'b1;
    setup(0, 2, 2, 3, 4, -10);
    avail[1] = 9;
    push_seg(1'b0, 1'b1, 1'b0, 2); push_seg(1'b1, 1'b1, 1'b0, 9 + 1 - 2);
    push_seg(1'b0, 1'b1, 1'b0, 2); push_seg(1'b1, 1'b1, 1'b0, 4);
    push_seg(1'b1, 1'b1, 1'b1, 1); push_seg(1'b1, 1'b0, 1'b0, 1);
    run_frame("late");
    check_val("underrun_set", {31'd0, underrun}, 32'd1);

    // Zero lengths behave as one tick; underrun clears at frame start.
    nbits = 2; bits[0] = 1'b0; bits[1] = 1'b1;
    setup(0, 1, 0, 0, 0, -10);
    push_seg(1'b0, 1'b1, 1'b0, 1); push_seg(1'b1, 1'b1, 1'b0, 1);
    push_seg(1'b0, 1'b1, 1'b0, 1); push_seg(1'b1, 1'b1, 1'b0, 1);
    push_seg(1'b1, 1'b1, 1'b1, 1); push_seg(1'b1, 1'b0, 1'b0, 1);
    run_frame("zero_len");
    check_val("underrun_clr", {31'd0, underrun}, 32'd0);

    // Abort in BIT_GAP with a bit buffered; a later abort in IDLE is ignored.
    nbits = 3; bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1;
    setup(0, 2, 3, 2, 2, 6);
    push_seg(1'b0, 1'b1, 1'b0, 2); push_seg(1'b1, 1'b1, 1'b0, 2);
    push_seg(1'b0, 1'b1, 1'b0, 2); push_seg(1'b1, 1'b1, 1'b1, 1);
    push_seg(1'b1, 1'b0, 1'b0, 4);
    run_frame("abort_gap");

    // Abort on the same cycle as a transfer: abort wins, bit dropped.
    nbits = 3; bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1;
    setup(0, 2, 3, 2, 2, 5);
    push_seg(1'b0, 1'b1, 1'b0, 2); push_seg(1'b1, 1'b1, 1'b0, 2);
    push_seg(1'b0, 1'b1, 1'b0, 1); push_seg(1'b1, 1'b1, 1'b1, 1);
    push_seg(1'b1, 1'b0, 1'b0, 3);
    run_frame("abort_xfer");

    // Reset during START_GAP restores the field at once, no done pulse.
    nbits = 1; bits[0] = 1'b0;
    setup(0, 5, 1, 1, 1, -10);
    push_seg(1'b0, 1'b1, 1'b0, 2);
    for (int i = 0; i < 3; i++) tick_cycle();
    check_val("pre_rst_field", {31'd0, field_on}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_val("rst_mid_field", {31'd0, field_on}, 32'd1);
    check_val("rst_mid_done",  {31'd0, done},     32'd0);
    check_val("rst_mid_busy",  {31'd0, busy},     32'd0);
    cmd_valid = 1'b0;
    bit_idx = nbits;
    @(negedge pck0);
    rst = 1'b0;
    @(negedge pck0);
    check_val("post_rst_done",  {31'd0, done},      32'd0);
    check_val("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("post_rst_field", {31'd0, field_on},  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
